mem_port_arbiter: RTL

- Shares the single byte-wide synchronous RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each 1/2/4-byte access into byte cycles and assembles read data little-endian.
- Returns a one-cycle done pulse to the requester that owns the transaction.
- Sits beside the pipeline. The ALU/execute stage never touches memory; IF and MEM stall on this block.

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one byte-wide synchronous RAM port between instruction fetch (IF)
//   and the load/store stage (MEM). Each 1/2/4-byte access is serialised into
//   byte cycles; read bytes are assembled little-endian. The owner of a
//   transaction gets a one-cycle done pulse.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush             cancels an in-flight IF result; blocks IF grant in IDLE
//   if_req/if_addr    IF word-read request, held until if_done or flush
//   if_done/if_rdata  IF completion pulse and fetched word
//   mem_req/mem_we/mem_len/mem_addr/mem_wdata
//                     MEM request (len 00 byte, 01 half, 1x word)
//   mem_done/mem_rdata MEM completion pulse and zero-extended load data
//   ram_a/ram_dout/ram_wr  registered RAM address, write byte, write enable
//   ram_din           RAM read byte, valid one cycle after its address
//   busy              transaction in progress (state != IDLE)
//
// States
//   IDLE   | arbitration; MEM has priority over IF
//   RD     | drive read address addr+k, capture byte k-1
//   RDLAST | address held, capture final byte, publish rdata
//   WR     | drive write address addr+k and byte k
//   DONE   | one-cycle done pulse, always returns to IDLE
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RDLAST = 3'd2,
        WR     = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q;
    logic              own_if_q;
    logic [1:0]        last_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic              flushed_q;
    logic              if_done_q;
    logic              mem_done_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_dout_q;
    logic              ram_wr_q;

    logic [1:0]        cnt_nxt_d;
    logic [1:0]        cnt_prv_d;
    logic [ADDR_W-1:0] addr_nxt_d;
    logic [31:0]       final_d;
    logic [1:0]        len_last_d;
    logic              if_cancel_d;

    assign cnt_nxt_d  = cnt_q + 2'd1;
    assign cnt_prv_d  = cnt_q - 2'd1;
    // Address arithmetic wraps naturally at ADDR_W bits.
    assign addr_nxt_d = addr_q + ADDR_W'(cnt_nxt_d);

    // Index of the last byte (N-1); length code 11 is treated as a word.
    always_comb begin
        len_last_d = 2'd3;
        case (mem_len)
            2'b00:   len_last_d = 2'd0;
            2'b01:   len_last_d = 2'd1;
            default: len_last_d = 2'd3;
        endcase
    end

    // In RDLAST the final byte arrives on ram_din; merge it into its lane.
    always_comb begin
        final_d = buf_q;
        final_d[{cnt_q, 3'b000} +: 8] = ram_din;
    end

    assign if_cancel_d = flushed_q | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            own_if_q    <= 1'b0;
            last_q      <= 2'd0;
            cnt_q       <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            flushed_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            ram_wr_q   <= 1'b0;

            if (state_q != IDLE && own_if_q && flush) begin
                flushed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        own_if_q  <= 1'b0;
                        last_q    <= len_last_d;
                        addr_q    <= mem_addr;
                        wdata_q   <= mem_wdata;
                        cnt_q     <= 2'd0;
                        buf_q     <= 32'd0;
                        flushed_q <= 1'b0;
                        ram_a_q   <= mem_addr;
                        if (mem_we) begin
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= mem_wdata[7:0];
                            state_q    <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end else if (if_req && !flush) begin
                        own_if_q  <= 1'b1;
                        last_q    <= 2'd3;
                        addr_q    <= if_addr;
                        cnt_q     <= 2'd0;
                        buf_q     <= 32'd0;
                        flushed_q <= 1'b0;
                        ram_a_q   <= if_addr;
                        state_q   <= RD;
                    end
                end
                RD: begin
                    // Byte k-1 arrives while address k is being driven.
                    if (cnt_q != 2'd0) begin
                        buf_q[{cnt_prv_d, 3'b000} +: 8] <= ram_din;
                    end
                    if (cnt_q == last_q) begin
                        state_q <= RDLAST;
                    end else begin
                        cnt_q   <= cnt_nxt_d;
                        ram_a_q <= addr_nxt_d;
                    end
                end
                RDLAST: begin
                    buf_q   <= final_d;
                    state_q <= DONE;
                    if (own_if_q) begin
                        if (!if_cancel_d) begin
                            if_rdata_q <= final_d;
                            if_done_q  <= 1'b1;
                        end
                    end else begin
                        mem_rdata_q <= final_d;
                        mem_done_q  <= 1'b1;
                    end
                end
                WR: begin
                    // Writes are only ever owned by MEM.
                    if (cnt_q == last_q) begin
                        mem_done_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q      <= cnt_nxt_d;
                        ram_a_q    <= addr_nxt_d;
                        ram_dout_q <= wdata_q[{cnt_nxt_d, 3'b000} +: 8];
                        ram_wr_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the DONE cycle itself still cancels the IF pulse.
    assign if_done   = if_done_q & ~flush;
    assign mem_done  = mem_done_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;
    assign busy      = (state_q != IDLE);

endmodule
